// File: rtl/mastermind_pkg.sv
// Shared definitions for the Mastermind timer and score display blocks.
package mastermind_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_e;

    localparam int LIMIT_SEC_DEFAULT = 30;
    localparam int BCD_W             = 4;

endpackage

// File: rtl/bin2bcd_2digit.sv
// Combinational binary (0..99) to two BCD digits, shared with the score display.
module bin2bcd_2digit
    import mastermind_pkg::*;
#(
    parameter int BIN_W = 7
) (
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones
);

    logic [BIN_W-1:0] clamped;

    // Out-of-range inputs saturate to 99 so the display never shows a non-decimal digit.
    always_comb begin
        clamped = (bin > BIN_W'(99)) ? BIN_W'(99) : bin;
        tens    = BCD_W'(clamped / BIN_W'(10));
        ones    = BCD_W'(clamped % BIN_W'(10));
    end

endmodule

// File: rtl/mastermind_guess_timer.sv
// Per-guess countdown: prescales divider ticks into seconds, counts down and flags expiry.
module mastermind_guess_timer
    import mastermind_pkg::*;
#(
    parameter int TICKS_PER_SEC = 4,
    parameter int TICK_W        = 8,
    parameter int LIMIT_SEC     = LIMIT_SEC_DEFAULT,
    parameter int SEC_W         = 7
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic [SEC_W-1:0] seconds_left,
    output logic [BCD_W-1:0] bcd_tens,
    output logic [BCD_W-1:0] bcd_ones,
    output logic             running,
    output logic             expired,
    output logic             expire_pulse
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [SEC_W-1:0]  SEC_LOAD  = SEC_W'(LIMIT_SEC);

    timer_state_e      state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [BCD_W-1:0]  tens_q, tens_d, ones_q, ones_d;
    logic              running_q, expired_q;
    logic              expire_pulse_q, expire_pulse_d;

    // Start wins over everything but reset and reloads from any state.
    always_comb begin
        state_d        = state_q;
        tick_cnt_d     = tick_cnt_q;
        sec_d          = sec_q;
        expire_pulse_d = 1'b0;
        if (start) begin
            state_d    = ST_RUN;
            sec_d      = SEC_LOAD;
            tick_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_IDLE;
                    end else if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (tick) begin
                        if (tick_cnt_q == TICK_LAST) begin
                            tick_cnt_d = '0;
                            // Guarding with <= keeps the counter from ever wrapping below zero.
                            if (sec_q <= SEC_W'(1)) begin
                                sec_d          = '0;
                                state_d        = ST_EXPIRED;
                                expire_pulse_d = 1'b1;
                            end else begin
                                sec_d = sec_q - SEC_W'(1);
                            end
                        end else begin
                            tick_cnt_d = tick_cnt_q + TICK_W'(1);
                        end
                    end
                end
                ST_PAUSED: begin
                    if (stop) begin
                        state_d = ST_IDLE;
                    end else if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    if (stop) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    bin2bcd_2digit #(
        .BIN_W(SEC_W)
    ) u_bcd (
        .bin (sec_d),
        .tens(tens_d),
        .ones(ones_d)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            tick_cnt_q     <= '0;
            sec_q          <= '0;
            tens_q         <= '0;
            ones_q         <= '0;
            running_q      <= 1'b0;
            expired_q      <= 1'b0;
            expire_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            sec_q          <= sec_d;
            tens_q         <= tens_d;
            ones_q         <= ones_d;
            running_q      <= (state_d == ST_RUN);
            expired_q      <= (state_d == ST_EXPIRED);
            expire_pulse_q <= expire_pulse_d;
        end
    end

    assign seconds_left = sec_q;
    assign bcd_tens     = tens_q;
    assign bcd_ones     = ones_q;
    assign running      = running_q;
    assign expired      = expired_q;
    assign expire_pulse = expire_pulse_q;

endmodule

// File: tb/tb_mastermind_guess_timer.sv
// Scoreboard bench: two timers (4 and 1 ticks per second) driven by shared directed and random stimulus.
module tb_mastermind_guess_timer;

    localparam int LIMIT = 30;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic tick    = 1'b0;
    logic start   = 1'b0;
    logic pause   = 1'b0;
    logic stop    = 1'b0;

    logic [6:0] sl4, sl1;
    logic [3:0] tn4, tn1, on4, on1;
    logic       run4, run1, exp4, exp1, pul4, pul1;

    always #5 clock = ~clock;

    mastermind_guess_timer #(
        .TICKS_PER_SEC(4), .TICK_W(8), .LIMIT_SEC(LIMIT), .SEC_W(7)
    ) dut4 (
        .clock(clock), .reset_n(reset_n), .tick(tick), .start(start), .pause(pause), .stop(stop),
        .seconds_left(sl4), .bcd_tens(tn4), .bcd_ones(on4),
        .running(run4), .expired(exp4), .expire_pulse(pul4)
    );

    mastermind_guess_timer #(
        .TICKS_PER_SEC(1), .TICK_W(8), .LIMIT_SEC(LIMIT), .SEC_W(7)
    ) dut1 (
        .clock(clock), .reset_n(reset_n), .tick(tick), .start(start), .pause(pause), .stop(stop),
        .seconds_left(sl1), .bcd_tens(tn1), .bcd_ones(on1),
        .running(run1), .expired(exp1), .expire_pulse(pul1)
    );

    // Reference: counted ticks since load; seconds shown = LIMIT - floor(counted / tps).
    typedef struct {
        bit run;
        bit paused;
        bit exp;
        bit pulse;
        int n;
        int sec;
    } model_t;

    typedef struct {
        int sec;
        bit run;
        bit exp;
        bit pulse;
    } expect_t;

    model_t  m4, m1;
    expect_t q4[$];
    expect_t q1[$];
    int      checks = 0;
    int      errors = 0;

    function automatic model_t step(model_t m, bit rn, bit st, bit ps, bit sp, bit tk, int tps);
        model_t r;
        r = m;
        r.pulse = 1'b0;
        if (!rn) begin
            r = '{default: 0};
        end else if (st) begin
            r.run = 1; r.paused = 0; r.exp = 0; r.n = 0; r.sec = LIMIT;
        end else if (!(m.run || m.paused || m.exp)) begin
            r = m;
            r.pulse = 1'b0;
        end else if (sp) begin
            r.run = 0; r.paused = 0; r.exp = 0;
        end else if (m.exp) begin
            r.exp = 1;
        end else if (m.paused) begin
            if (!ps) begin r.paused = 0; r.run = 1; end
        end else if (ps) begin
            r.run = 0; r.paused = 1;
        end else if (tk) begin
            r.n = m.n + 1;
            r.sec = LIMIT - r.n / tps;
            if (r.sec <= 0) begin
                r.sec = 0; r.run = 0; r.exp = 1; r.pulse = 1;
            end
        end
        return r;
    endfunction

    function automatic expect_t to_exp(model_t m);
        expect_t e;
        e.sec = m.sec; e.run = m.run; e.exp = m.exp; e.pulse = m.pulse;
        return e;
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare(string tag, expect_t e, int sl, int tn, int on, int rn, int ex, int pu);
        check({tag, ".seconds_left"}, sl, e.sec);
        check({tag, ".bcd_tens"}, tn, e.sec / 10);
        check({tag, ".bcd_ones"}, on, e.sec % 10);
        check({tag, ".running"}, rn, int'(e.run));
        check({tag, ".expired"}, ex, int'(e.exp));
        check({tag, ".expire_pulse"}, pu, int'(e.pulse));
    endtask

    // Drive one cycle of inputs and queue the response the outputs must show after the next edge.
    task automatic drive(bit rn, bit st, bit ps, bit sp, bit tk);
        @(negedge clock);
        reset_n = rn; start = st; pause = ps; stop = sp; tick = tk;
        m4 = step(m4, rn, st, ps, sp, tk, 4);
        m1 = step(m1, rn, st, ps, sp, tk, 1);
        q4.push_back(to_exp(m4));
        q1.push_back(to_exp(m1));
    endtask

    task automatic ticks(int count, bit ps);
        for (int i = 0; i < count; i++) drive(1, 0, ps, 0, 1);
    endtask

    // Monitor: registered outputs are compared shortly after each active edge.
    initial begin
        expect_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q4.size() > 0) begin
                e = q4.pop_front();
                compare("tps4", e, int'(sl4), int'(tn4), int'(on4), int'(run4), int'(exp4), int'(pul4));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                compare("tps1", e, int'(sl1), int'(tn1), int'(on1), int'(run1), int'(exp1), int'(pul1));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rn, st, sp, tk, plvl;
        m4 = '{default: 0};
        m1 = '{default: 0};

        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 1, 1, 1);            // idle ignores pause/stop/tick
        drive(1, 1, 0, 0, 0);            // start
        ticks(4, 0);                     // 29 on dut4
        drive(1, 0, 0, 0, 0);
        ticks(116, 0);                   // expiry on dut4
        ticks(10, 0);                    // stays 0, no second pulse
        drive(1, 0, 1, 0, 1);            // pause ignored in EXPIRED

        drive(1, 1, 0, 0, 0);            // restart from EXPIRED
        ticks(2, 0);                     // tick_cnt = 2
        drive(1, 0, 1, 0, 0);            // pause
        ticks(8, 1);                     // ignored while paused
        drive(1, 0, 0, 0, 1);            // release with tick: not counted
        ticks(2, 0);                     // second completes on the 2nd tick
        drive(1, 0, 0, 0, 0);

        drive(1, 1, 0, 0, 1);            // start + tick together
        drive(1, 0, 0, 1, 0);            // stop: hold 30
        drive(1, 0, 0, 0, 1);

        drive(1, 1, 0, 0, 0);
        ticks(52, 0);                    // dut4 reaches 17
        drive(0, 0, 0, 0, 1);            // reset mid-countdown
        ticks(5, 0);                     // ignored in IDLE
        drive(1, 1, 0, 0, 0);
        ticks(40, 0);                    // dut1 expires
        drive(1, 1, 0, 0, 0);            // restart from EXPIRED
        ticks(3, 0);
        drive(1, 0, 1, 1, 1);            // stop beats pause
        drive(1, 0, 0, 0, 0);

        plvl = 1'b0;
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            rn = ($urandom_range(0, 299) != 0);
            st = ($urandom_range(0, 99) == 0);
            sp = ($urandom_range(0, 99) == 0);
            tk = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) plvl = ~plvl;
            if ($urandom_range(0, 149) == 0) st = 1'b1;
            drive(rn, st, plvl, sp, tk);
        end
        drive(1, 0, 0, 0, 0);

        @(negedge clock);
        @(negedge clock);
        check("queue_drained_tps4", q4.size(), 0);
        check("queue_drained_tps1", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
